reg_access_master: RTL and testbench

Byte-stream command initiator that drives the write and read ports of the register file. Accepts host command bytes (e.g. from a UART receiver) on a valid/ready stream, decodes them into single-cycle register writes or reads, and returns acknowledge or read-data bytes on a second valid/ready stream. It is the initiator side of the register-file access interface.

---
 rtl/reg_access_master_if.sv | 32 +++
 rtl/reg_access_master.sv | 178 +++++++++++++++++
 tb/tb_reg_access_master.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_access_master_if.sv
// Register-file access bundle between the command initiator (master) and the
// host stream / register file side (slave).
interface reg_access_master_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 5
);
    logic             i_cmd_valid;
    logic [7:0]       i_cmd_data;
    logic             o_cmd_ready;
    logic             o_rsp_valid;
    logic [7:0]       o_rsp_data;
    logic             i_rsp_ready;
    logic             o_w_en;
    logic [AW-1:0]    o_w_addr;
    logic [WIDTH-1:0] o_w_value;
    logic             o_r_en;
    logic [AW-1:0]    o_r_addr;
    logic [WIDTH-1:0] i_r_value;
    logic             o_busy;

    modport master (
        input  i_cmd_valid, i_cmd_data, i_rsp_ready, i_r_value,
        output o_cmd_ready, o_rsp_valid, o_rsp_data, o_w_en, o_w_addr,
               o_w_value, o_r_en, o_r_addr, o_busy
    );

    modport slave (
        output i_cmd_valid, i_cmd_data, i_rsp_ready, i_r_value,
        input  o_cmd_ready, o_rsp_valid, o_rsp_data, o_w_en, o_w_addr,
               o_w_value, o_r_en, o_r_addr, o_busy
    );
endinterface

// File: rtl/reg_access_master.sv
// Byte-stream command initiator: decodes header/data bytes into single-cycle
// register writes or reads and streams back an ack, error or read-data bytes.
// All outputs are registered; the control outputs are derived from the next
// state so they line up exactly with the state they describe.
module reg_access_master #(
    parameter int WIDTH        = 16,
    parameter int DEPTH        = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    reg_access_master_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = WIDTH / 8;
    localparam logic [3:0]       LAST_BYTE = 4'(NB - 1);
    localparam logic [1:0]       LAST_LAT  = 2'(READ_LATENCY - 1);
    localparam logic [7:0]       ADDR_MASK = 8'((32'd1 << AW) - 32'd1);
    localparam logic [7:0]       RSV_MASK  = 8'h7F & ~ADDR_MASK;
    localparam logic [WIDTH-1:0] ACK_WORD  = WIDTH'(8'hA5) << (WIDTH - 8);
    localparam logic [WIDTH-1:0] ERR_WORD  = WIDTH'(8'hEE) << (WIDTH - 8);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WDATA = 3'd1,
        WSTB  = 3'd2,
        RSTB  = 3'd3,
        RWAIT = 3'd4,
        RESP  = 3'd5
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             cmd_acc_s;
    logic             rsp_acc_s;
    logic             hdr_bad_s;

    logic             cmd_ready_r;
    logic             rsp_valid_r;
    logic             busy_r;
    logic             w_en_r;
    logic             r_en_r;
    logic [AW-1:0]    addr_r;
    logic [WIDTH-1:0] w_value_r;
    logic [WIDTH-1:0] rsp_shift_r;
    logic [3:0]       byte_cnt_r;
    logic [3:0]       rsp_cnt_r;
    logic [3:0]       rsp_len_r;
    logic [1:0]       lat_cnt_r;

    assign bus.o_cmd_ready = cmd_ready_r;
    assign bus.o_rsp_valid = rsp_valid_r;
    assign bus.o_rsp_data  = rsp_shift_r[WIDTH-1 -: 8];
    assign bus.o_w_en      = w_en_r;
    assign bus.o_w_addr    = addr_r;
    assign bus.o_w_value   = w_value_r;
    assign bus.o_r_en      = r_en_r;
    assign bus.o_r_addr    = addr_r;
    assign bus.o_busy      = busy_r;

    // Next-state decode and stream handshake qualification.
    always_comb begin
        state_nxt_s = state_r;
        cmd_acc_s   = bus.i_cmd_valid && cmd_ready_r;
        rsp_acc_s   = rsp_valid_r && bus.i_rsp_ready;
        hdr_bad_s   = (bus.i_cmd_data & RSV_MASK) != 8'h00;
        case (state_r)
            IDLE: begin
                if (cmd_acc_s) begin
                    if (hdr_bad_s) begin
                        state_nxt_s = RESP;
                    end else if (bus.i_cmd_data[7]) begin
                        state_nxt_s = WDATA;
                    end else begin
                        state_nxt_s = RSTB;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WDATA: begin
                if (cmd_acc_s && (byte_cnt_r == LAST_BYTE)) begin
                    state_nxt_s = WSTB;
                end else begin
                    state_nxt_s = WDATA;
                end
            end
            WSTB:  state_nxt_s = RESP;
            RSTB:  state_nxt_s = RWAIT;
            RWAIT: begin
                if (lat_cnt_r == LAST_LAT) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = RWAIT;
                end
            end
            RESP: begin
                if (rsp_acc_s && (rsp_cnt_r == rsp_len_r)) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered control outputs, command capture, counters and response shifter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            w_en_r      <= 1'b0;
            r_en_r      <= 1'b0;
            addr_r      <= '0;
            w_value_r   <= '0;
            rsp_shift_r <= '0;
            byte_cnt_r  <= 4'd0;
            rsp_cnt_r   <= 4'd0;
            rsp_len_r   <= 4'd0;
            lat_cnt_r   <= 2'd0;
        end else begin
            cmd_ready_r <= (state_nxt_s == IDLE) || (state_nxt_s == WDATA);
            rsp_valid_r <= (state_nxt_s == RESP);
            busy_r      <= (state_nxt_s != IDLE);
            w_en_r      <= (state_nxt_s == WSTB);
            r_en_r      <= (state_nxt_s == RSTB);
            case (state_r)
                IDLE: begin
                    if (cmd_acc_s) begin
                        // Error word is preloaded; write and read paths overwrite it later.
                        addr_r      <= bus.i_cmd_data[AW-1:0];
                        byte_cnt_r  <= 4'd0;
                        lat_cnt_r   <= 2'd0;
                        rsp_cnt_r   <= 4'd0;
                        rsp_len_r   <= 4'd0;
                        rsp_shift_r <= ERR_WORD;
                    end
                end
                WDATA: begin
                    if (cmd_acc_s) begin
                        w_value_r  <= (w_value_r << 8) | WIDTH'(bus.i_cmd_data);
                        byte_cnt_r <= (byte_cnt_r == LAST_BYTE) ? 4'd0 : byte_cnt_r + 4'd1;
                    end
                end
                WSTB: begin
                    rsp_shift_r <= ACK_WORD;
                end
                RWAIT: begin
                    if (lat_cnt_r == LAST_LAT) begin
                        rsp_shift_r <= bus.i_r_value;
                        rsp_len_r   <= LAST_BYTE;
                    end else begin
                        lat_cnt_r <= lat_cnt_r + 2'd1;
                    end
                end
                RESP: begin
                    if (rsp_acc_s) begin
                        rsp_shift_r <= rsp_shift_r << 8;
                        rsp_cnt_r   <= rsp_cnt_r + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reg_access_master.sv
// Directed bench for reg_access_master: a READ_LATENCY=1 and a READ_LATENCY=3
// instance, each beside a small register-file model. Expected responses and
// strobes are queued when commands are driven and checked as the DUT emits them.
module tb_reg_access_master;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    reg_access_master_if #(.WIDTH(16), .AW(5)) b1 ();
    reg_access_master_if #(.WIDTH(16), .AW(5)) b3 ();

    reg_access_master #(.WIDTH(16), .DEPTH(32), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(b1)
    );
    reg_access_master #(.WIDTH(16), .DEPTH(32), .READ_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .bus(b3)
    );

    // Register-file models: read data is valid only in the exact latency cycle.
    logic [15:0] regs1 [32];
    logic [15:0] regs3 [32];
    logic        vld1_r;
    logic [15:0] dat1_r;
    logic [2:0]  vld3_r;
    logic [15:0] dat3_r [3];

    always @(posedge clk) begin
        if (b1.o_w_en) regs1[b1.o_w_addr] <= b1.o_w_value;
        if (b3.o_w_en) regs3[b3.o_w_addr] <= b3.o_w_value;
        vld1_r    <= b1.o_r_en;
        dat1_r    <= regs1[b1.o_r_addr];
        vld3_r    <= {vld3_r[1:0], b3.o_r_en};
        dat3_r[0] <= regs3[b3.o_r_addr];
        dat3_r[1] <= dat3_r[0];
        dat3_r[2] <= dat3_r[1];
    end

    assign b1.i_r_value = vld1_r    ? dat1_r    : 16'hDEAD;
    assign b3.i_r_value = vld3_r[2] ? dat3_r[2] : 16'hDEAD;

    // Scoreboards
    logic [7:0]  exp_rsp1 [$];
    logic [7:0]  exp_rsp3 [$];
    logic [20:0] exp_wr1  [$];
    logic [20:0] exp_wr3  [$];
    logic [4:0]  exp_rd1  [$];
    logic [4:0]  exp_rd3  [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs1();
        return 64'({b1.o_cmd_ready, b1.o_rsp_valid, b1.o_rsp_data, b1.o_w_en, b1.o_w_addr,
                    b1.o_w_value, b1.o_r_en, b1.o_r_addr, b1.o_busy});
    endfunction

    function automatic logic [63:0] outs3();
        return 64'({b3.o_cmd_ready, b3.o_rsp_valid, b3.o_rsp_data, b3.o_w_en, b3.o_w_addr,
                    b3.o_w_value, b3.o_r_en, b3.o_r_addr, b3.o_busy});
    endfunction

    task automatic observe(input int sel, input logic rsp_fire, input logic [7:0] rsp_data,
                           input logic w_en, input logic [4:0] w_addr, input logic [15:0] w_value,
                           input logic r_en, input logic [4:0] r_addr);
        int          sz;
        logic [7:0]  e8;
        logic [20:0] e21;
        logic [4:0]  e5;
        if (rsp_fire) begin
            sz = (sel == 0) ? exp_rsp1.size() : exp_rsp3.size();
            chk($sformatf("rsp_pending[%0d]", sel), 64'(sz != 0), 64'd1);
            if (sz != 0) begin
                if (sel == 0) e8 = exp_rsp1.pop_front();
                else          e8 = exp_rsp3.pop_front();
                chk($sformatf("rsp_byte[%0d]", sel), 64'(rsp_data), 64'(e8));
            end
        end
        if (w_en) begin
            sz = (sel == 0) ? exp_wr1.size() : exp_wr3.size();
            chk($sformatf("w_en_expected[%0d]", sel), 64'(sz != 0), 64'd1);
            if (sz != 0) begin
                if (sel == 0) e21 = exp_wr1.pop_front();
                else          e21 = exp_wr3.pop_front();
                chk($sformatf("w_addr_value[%0d]", sel), 64'({w_addr, w_value}), 64'(e21));
            end
        end
        if (r_en) begin
            sz = (sel == 0) ? exp_rd1.size() : exp_rd3.size();
            chk($sformatf("r_en_expected[%0d]", sel), 64'(sz != 0), 64'd1);
            if (sz != 0) begin
                if (sel == 0) e5 = exp_rd1.pop_front();
                else          e5 = exp_rd3.pop_front();
                chk($sformatf("r_addr[%0d]", sel), 64'(r_addr), 64'(e5));
            end
        end
        if (w_en || r_en) chk($sformatf("strobe_excl[%0d]", sel), 64'(w_en && r_en), 64'd0);
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            observe(0, b1.o_rsp_valid && b1.i_rsp_ready, b1.o_rsp_data, b1.o_w_en, b1.o_w_addr,
                    b1.o_w_value, b1.o_r_en, b1.o_r_addr);
            observe(1, b3.o_rsp_valid && b3.i_rsp_ready, b3.o_rsp_data, b3.o_w_en, b3.o_w_addr,
                    b3.o_w_value, b3.o_r_en, b3.o_r_addr);
        end
    end

    task automatic send_byte(input int sel, input logic [7:0] d);
        bit ok = 1'b0;
        if (sel == 0) begin b1.i_cmd_valid = 1'b1; b1.i_cmd_data = d; end
        else          begin b3.i_cmd_valid = 1'b1; b3.i_cmd_data = d; end
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = (sel == 0) ? b1.o_cmd_ready : b3.o_cmd_ready;
        end
        @(posedge clk);
        #1;
        if (sel == 0) b1.i_cmd_valid = 1'b0;
        else          b3.i_cmd_valid = 1'b0;
        chk($sformatf("cmd_accept[%0d]", sel), 64'(ok), 64'd1);
    endtask

    task automatic wait_idle(input int sel);
        bit idle = 1'b0;
        for (int i = 0; i < 100 && !idle; i++) begin
            @(posedge clk);
            #1;
            idle = (sel == 0) ? !b1.o_busy : !b3.o_busy;
        end
        chk($sformatf("idle_reached[%0d]", sel), 64'(idle), 64'd1);
        chk($sformatf("idle_ready[%0d]", sel),
            64'((sel == 0) ? b1.o_cmd_ready : b3.o_cmd_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        b1.i_cmd_valid = 1'b0; b1.i_cmd_data = 8'h00; b1.i_rsp_ready = 1'b1;
        b3.i_cmd_valid = 1'b0; b3.i_cmd_data = 8'h00; b3.i_rsp_ready = 1'b1;

        // Reset and release
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs_dut1", outs1(), 64'd0);
        chk("reset_outs_dut3", outs3(), 64'd0);
        reset = 1'b1;
        chk("ready_before_edge", 64'(b1.o_cmd_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("ready_after_release", 64'(b1.o_cmd_ready), 64'd1);
        chk("busy_after_release", 64'(b1.o_busy), 64'd0);

        // Write 0x83 0x12 0x34
        exp_wr1.push_back({5'd3, 16'h1234});
        exp_rsp1.push_back(8'hA5);
        send_byte(0, 8'h83);
        chk("wdata_ready", 64'(b1.o_cmd_ready), 64'd1);
        chk("wdata_busy", 64'(b1.o_busy), 64'd1);
        send_byte(0, 8'h12);
        send_byte(0, 8'h34);
        chk("w_en_timing", 64'(b1.o_w_en), 64'd1);
        chk("wstb_not_ready", 64'(b1.o_cmd_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("w_en_one_cycle", 64'(b1.o_w_en), 64'd0);
        chk("ack_timing", 64'(b1.o_rsp_valid), 64'd1);
        wait_idle(0);

        // Read 0x03 with response stalled for three cycles
        exp_rd1.push_back(5'd3);
        exp_rsp1.push_back(8'h12);
        exp_rsp1.push_back(8'h34);
        b1.i_rsp_ready = 1'b0;
        send_byte(0, 8'h03);
        chk("r_en_timing", 64'(b1.o_r_en), 64'd1);
        chk("r_addr_direct", 64'(b1.o_r_addr), 64'd3);
        @(posedge clk);
        #1;
        chk("rwait_no_rsp", 64'(b1.o_rsp_valid), 64'd0);
        chk("r_en_one_cycle", 64'(b1.o_r_en), 64'd0);
        @(posedge clk);
        #1;
        chk("read_rsp_timing", 64'(b1.o_rsp_valid), 64'd1);
        chk("stall_data_0", 64'(b1.o_rsp_data), 64'h12);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("stall_valid_held", 64'(b1.o_rsp_valid), 64'd1);
            chk("stall_data_held", 64'(b1.o_rsp_data), 64'h12);
        end
        b1.i_rsp_ready = 1'b1;
        wait_idle(0);

        // Bad header 0x60, then a normal write with gaps and a read-back
        exp_rsp1.push_back(8'hEE);
        send_byte(0, 8'h60);
        chk("bad_rsp_valid", 64'(b1.o_rsp_valid), 64'd1);
        chk("bad_rsp_data", 64'(b1.o_rsp_data), 64'hEE);
        chk("bad_not_ready", 64'(b1.o_cmd_ready), 64'd0);
        wait_idle(0);
        exp_wr1.push_back({5'd1, 16'h55AA});
        exp_rsp1.push_back(8'hA5);
        send_byte(0, 8'h81);
        repeat (3) @(posedge clk);
        #1;
        chk("gap_stall_ready", 64'(b1.o_cmd_ready), 64'd1);
        send_byte(0, 8'h55);
        repeat (2) @(posedge clk);
        #1;
        send_byte(0, 8'hAA);
        wait_idle(0);
        exp_rd1.push_back(5'd1);
        exp_rsp1.push_back(8'h55);
        exp_rsp1.push_back(8'hAA);
        send_byte(0, 8'h01);
        wait_idle(0);

        // Reset in the middle of a write command
        send_byte(0, 8'h85);
        send_byte(0, 8'hAB);
        reset = 1'b0;
        #1;
        chk("mid_reset_outs", outs1(), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_reset_ready", 64'(b1.o_cmd_ready), 64'd1);
        exp_wr1.push_back({5'd5, 16'hCDEF});
        exp_rsp1.push_back(8'hA5);
        send_byte(0, 8'h85);
        send_byte(0, 8'hCD);
        send_byte(0, 8'hEF);
        chk("w_value_after_reset", 64'(b1.o_w_value), 64'hCDEF);
        wait_idle(0);

        // READ_LATENCY = 3 instance
        exp_wr3.push_back({5'h1F, 16'hBEEF});
        exp_rsp3.push_back(8'hA5);
        send_byte(1, 8'h9F);
        send_byte(1, 8'hBE);
        send_byte(1, 8'hEF);
        wait_idle(1);
        exp_rd3.push_back(5'h1F);
        exp_rsp3.push_back(8'hBE);
        exp_rsp3.push_back(8'hEF);
        send_byte(1, 8'h1F);
        chk("l3_r_en", 64'(b3.o_r_en), 64'd1);
        chk("l3_r_addr", 64'(b3.o_r_addr), 64'h1F);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("l3_no_rsp_yet", 64'(b3.o_rsp_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        chk("l3_rsp_timing", 64'(b3.o_rsp_valid), 64'd1);
        chk("l3_rsp_first", 64'(b3.o_rsp_data), 64'hBE);
        wait_idle(1);

        // Everything queued must have been consumed
        repeat (2) @(posedge clk);
        chk("rsp_queue_drained", 64'(exp_rsp1.size() + exp_rsp3.size()), 64'd0);
        chk("wr_queue_drained", 64'(exp_wr1.size() + exp_wr3.size()), 64'd0);
        chk("rd_queue_drained", 64'(exp_rd1.size() + exp_rd3.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
